// File: rtl/llc_pkg.sv
// Shared definitions for the last-level cache: geometry, coherence enums,
// the per-line record and the simulated snoop response of the other caches.
package LLC_defs;
    localparam int NUM_SETS      = 16384;
    localparam int ASSOCIATIVITY = 16;
    localparam int INDEX_W       = 14;
    localparam int TAG_W         = 12;
    localparam int WAY_W         = 4;
    localparam int PLRU_W        = 15;

    typedef enum logic [2:0] {READ, WRITE, INVALIDATE, RWIM, NOBUSOP} busOperation;
    typedef enum logic [1:0] {NOHIT, HIT, HITM, NORESULT} snoopResults;
    typedef enum logic [2:0] {GETLINE, SENDLINE, INVALIDATELINE, EVICTLINE, NOMESSAGE} messages;
    typedef enum logic [1:0] {I, S, E, M} mesiStates;
    typedef enum logic       {ST_IDLE, ST_FILL} fill_state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        mesiStates        mesi;
    } cache;

    localparam cache LINE_INVALID = '{valid: 1'b0, tag: 12'd0, mesi: I};

    // Other processors' answer to our READ/RWIM, encoded in the low address bits.
    function automatic snoopResults sim_snoop(input logic [1:0] lsb);
        snoopResults r;
        case (lsb)
            2'b00:   r = HIT;
            2'b01:   r = HITM;
            default: r = NOHIT;
        endcase
        return r;
    endfunction
endpackage

// File: rtl/llc_plru.sv
// Tree pseudo-LRU for one 16-way set: bit 1 at a node means the victim lies
// in its right subtree; an access flips its path to point away from it.
module llc_plru
    import LLC_defs::*;
(
    input  logic [PLRU_W-1:0] tree,
    input  logic [WAY_W-1:0]  access_way,
    output logic [WAY_W-1:0]  victim,
    output logic [PLRU_W-1:0] tree_next
);

    logic [3:0] vnode_s;
    logic [3:0] unode_s;

    // Walk from the root following the node bits to find the victim.
    always_comb begin
        victim  = '0;
        vnode_s = 4'd0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            victim[WAY_W-1-lvl] = tree[vnode_s];
            vnode_s = {vnode_s[2:0], 1'b0} + 4'd1 + {3'd0, tree[vnode_s]};
        end
    end

    // Walk the accessed way's path and point each node at the other half.
    always_comb begin
        tree_next = tree;
        unode_s   = 4'd0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            tree_next[unode_s] = ~access_way[WAY_W-1-lvl];
            unode_s = {unode_s[2:0], 1'b0} + 4'd1 + {3'd0, access_way[WAY_W-1-lvl]};
        end
    end

endmodule

// File: rtl/llc.sv
// Shared last-level cache with MESI coherence, one trace operation per cycle.
// A miss that must displace a valid line takes two cycles, flagged by hold.
module llc
    import LLC_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] op,
    output logic [31:0] cacheRds,
    output logic [31:0] cacheWrs,
    output logic [31:0] cacheHits,
    output logic [31:0] cacheMisses,
    output busOperation busOp,
    output snoopResults snoopResult,
    output messages     message,
    output cache        LLC_cache [NUM_SETS][ASSOCIATIVITY],
    output logic [31:0] hold
);

    fill_state_e        state_q, state_d;
    logic [31:0]        op_l_q, op_l_d, addr_l_q, addr_l_d;
    logic [WAY_W-1:0]   way_l_q, way_l_d;
    logic [31:0]        rds_q, rds_d, wrs_q, wrs_d, hits_q, hits_d, misses_q, misses_d;
    busOperation        bus_op_q, bus_op_d;
    snoopResults        snoop_q, snoop_d;
    messages            msg_q, msg_d;
    logic               hold_q, hold_d;
    logic [PLRU_W-1:0]  plru_q [NUM_SETS];
    logic [PLRU_W-1:0]  plru_d [NUM_SETS];
    cache               cache_d [NUM_SETS][ASSOCIATIVITY];

    logic [31:0]        eff_op_s, eff_addr_s;
    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    snoopResults        sim_s;
    logic               unused_addr_s;
    logic               hit_s, has_inv_s, match_s;
    logic [WAY_W-1:0]   hit_way_s, inv_way_s, victim_s, access_way_s;
    mesiStates          hit_mesi_s;
    logic [PLRU_W-1:0]  tree_next_s;
    logic               wr_en_s, plru_upd_s, clear_all_s, do_fill_s;
    logic [WAY_W-1:0]   wr_way_s, fill_way_s;
    cache               wr_line_s;

    // The second cycle of an eviction works on the operation latched in the first.
    assign eff_op_s      = (state_q == ST_FILL) ? op_l_q : op;
    assign eff_addr_s    = (state_q == ST_FILL) ? addr_l_q : addr;
    assign idx_s         = eff_addr_s[19:6];
    assign tag_s         = eff_addr_s[31:20];
    assign sim_s         = sim_snoop(eff_addr_s[1:0]);
    assign unused_addr_s = ^eff_addr_s[5:2];

    assign cacheRds    = rds_q;
    assign cacheWrs    = wrs_q;
    assign cacheHits   = hits_q;
    assign cacheMisses = misses_q;
    assign busOp       = bus_op_q;
    assign snoopResult = snoop_q;
    assign message     = msg_q;
    assign hold        = {31'd0, hold_q};

    llc_plru u_plru (
        .tree       (plru_q[idx_s]),
        .access_way (access_way_s),
        .victim     (victim_s),
        .tree_next  (tree_next_s)
    );

    // Tag lookup; scanning downward leaves the lowest invalid way selected.
    always_comb begin
        hit_s      = 1'b0;
        hit_way_s  = '0;
        hit_mesi_s = I;
        has_inv_s  = 1'b0;
        inv_way_s  = '0;
        match_s    = 1'b0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            match_s    = LLC_cache[idx_s][w].valid && (LLC_cache[idx_s][w].tag == tag_s);
            hit_s      = hit_s | match_s;
            hit_way_s  = match_s ? WAY_W'(w) : hit_way_s;
            hit_mesi_s = match_s ? LLC_cache[idx_s][w].mesi : hit_mesi_s;
            has_inv_s  = has_inv_s | ~LLC_cache[idx_s][w].valid;
            inv_way_s  = LLC_cache[idx_s][w].valid ? inv_way_s : WAY_W'(w);
        end
    end

    // Operation decode: next outputs, counters and the single line/PLRU update.
    always_comb begin
        state_d      = state_q;
        op_l_d       = op_l_q;
        addr_l_d     = addr_l_q;
        way_l_d      = way_l_q;
        rds_d        = rds_q;
        wrs_d        = wrs_q;
        hits_d       = hits_q;
        misses_d     = misses_q;
        bus_op_d     = NOBUSOP;
        snoop_d      = NORESULT;
        msg_d        = NOMESSAGE;
        hold_d       = 1'b0;
        wr_en_s      = 1'b0;
        wr_way_s     = hit_way_s;
        wr_line_s    = '{valid: 1'b1, tag: tag_s, mesi: M};
        plru_upd_s   = 1'b0;
        access_way_s = hit_way_s;
        clear_all_s  = 1'b0;
        do_fill_s    = 1'b0;
        fill_way_s   = way_l_q;
        if (state_q == ST_FILL) begin
            state_d   = ST_IDLE;
            snoop_d   = sim_s;
            do_fill_s = 1'b1;
        end else begin
            case (op)
                32'd0, 32'd1, 32'd2: begin
                    snoop_d = sim_s;
                    if (op == 32'd1) begin
                        wrs_d = wrs_q + 32'd1;
                    end else begin
                        rds_d = rds_q + 32'd1;
                    end
                    if (hit_s) begin
                        hits_d     = hits_q + 32'd1;
                        plru_upd_s = 1'b1;
                        if (op == 32'd1) begin
                            wr_en_s  = 1'b1;
                            bus_op_d = (hit_mesi_s == S) ? INVALIDATE : NOBUSOP;
                        end else begin
                            msg_d = SENDLINE;
                        end
                    end else if (has_inv_s) begin
                        misses_d   = misses_q + 32'd1;
                        do_fill_s  = 1'b1;
                        fill_way_s = inv_way_s;
                    end else begin
                        misses_d = misses_q + 32'd1;
                        hold_d   = 1'b1;
                        msg_d    = EVICTLINE;
                        bus_op_d = (LLC_cache[idx_s][victim_s].mesi == M) ? WRITE : NOBUSOP;
                        state_d  = ST_FILL;
                        op_l_d   = op;
                        addr_l_d = addr;
                        way_l_d  = victim_s;
                    end
                end
                32'd3: begin
                    if (hit_s) begin
                        wr_en_s        = 1'b1;
                        wr_line_s.mesi = S;
                        snoop_d        = (hit_mesi_s == M) ? HITM : HIT;
                        msg_d          = (hit_mesi_s == M) ? GETLINE : NOMESSAGE;
                    end else begin
                        snoop_d = NOHIT;
                    end
                end
                32'd4: snoop_d = NORESULT;
                32'd5: begin
                    if (hit_s) begin
                        wr_en_s   = 1'b1;
                        wr_line_s = '{valid: 1'b0, tag: tag_s, mesi: I};
                        snoop_d   = (hit_mesi_s == M) ? HITM : HIT;
                        msg_d     = (hit_mesi_s == M) ? EVICTLINE : INVALIDATELINE;
                    end else begin
                        snoop_d = NOHIT;
                    end
                end
                32'd6: begin
                    if (hit_s && (hit_mesi_s == S)) begin
                        wr_en_s   = 1'b1;
                        wr_line_s = '{valid: 1'b0, tag: tag_s, mesi: I};
                        snoop_d   = HIT;
                        msg_d     = INVALIDATELINE;
                    end else begin
                        snoop_d = NOHIT;
                    end
                end
                32'd8: begin
                    clear_all_s = 1'b1;
                    rds_d       = 32'd0;
                    wrs_d       = 32'd0;
                    hits_d      = 32'd0;
                    misses_d    = 32'd0;
                end
                default: clear_all_s = 1'b0;
            endcase
        end
        if (do_fill_s) begin
            plru_upd_s   = 1'b1;
            access_way_s = fill_way_s;
            wr_en_s      = 1'b1;
            wr_way_s     = fill_way_s;
            msg_d        = SENDLINE;
            if (eff_op_s == 32'd1) begin
                bus_op_d  = RWIM;
                wr_line_s = '{valid: 1'b1, tag: tag_s, mesi: M};
            end else begin
                bus_op_d  = READ;
                wr_line_s = '{valid: 1'b1, tag: tag_s, mesi: (sim_s == NOHIT) ? E : S};
            end
        end else begin
            fill_way_s = fill_way_s;
        end
    end

    // Next tag/state array and PLRU trees: flush everything or patch one entry.
    always_comb begin
        cache_d = LLC_cache;
        plru_d  = plru_q;
        if (clear_all_s) begin
            cache_d = '{default: '{default: LINE_INVALID}};
            plru_d  = '{default: 15'd0};
        end else begin
            if (wr_en_s) begin
                cache_d[idx_s][wr_way_s] = wr_line_s;
            end else begin
                cache_d = LLC_cache;
            end
            if (plru_upd_s) begin
                plru_d[idx_s] = tree_next_s;
            end else begin
                plru_d = plru_q;
            end
        end
    end

    // All architectural state; reset also aborts a pending fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_l_q    <= 32'd0;
            addr_l_q  <= 32'd0;
            way_l_q   <= '0;
            rds_q     <= 32'd0;
            wrs_q     <= 32'd0;
            hits_q    <= 32'd0;
            misses_q  <= 32'd0;
            bus_op_q  <= NOBUSOP;
            snoop_q   <= NORESULT;
            msg_q     <= NOMESSAGE;
            hold_q    <= 1'b0;
            LLC_cache <= '{default: '{default: LINE_INVALID}};
            plru_q    <= '{default: 15'd0};
        end else begin
            state_q   <= state_d;
            op_l_q    <= op_l_d;
            addr_l_q  <= addr_l_d;
            way_l_q   <= way_l_d;
            rds_q     <= rds_d;
            wrs_q     <= wrs_d;
            hits_q    <= hits_d;
            misses_q  <= misses_d;
            bus_op_q  <= bus_op_d;
            snoop_q   <= snoop_d;
            msg_q     <= msg_d;
            hold_q    <= hold_d;
            LLC_cache <= cache_d;
            plru_q    <= plru_d;
        end
    end

endmodule

// File: tb/tb_llc.sv
// Directed bench for the MESI last-level cache; expected values are hand-derived.
module tb_llc;
    import LLC_defs::*;

    logic        clk, rst;
    logic [31:0] addr, op;
    logic [31:0] cacheRds, cacheWrs, cacheHits, cacheMisses, hold;
    busOperation busOp;
    snoopResults snoopResult;
    messages     message;
    cache        llc_arr [NUM_SETS][ASSOCIATIVITY];

    int tests_run = 0;
    int fails     = 0;

    localparam logic [13:0] IDX = 14'h0676;
    localparam logic [31:0] A0  = 32'h10019d94;

    llc dut (
        .clk(clk), .rst(rst), .addr(addr), .op(op),
        .cacheRds(cacheRds), .cacheWrs(cacheWrs), .cacheHits(cacheHits), .cacheMisses(cacheMisses),
        .busOp(busOp), .snoopResult(snoopResult), .message(message),
        .LLC_cache(llc_arr), .hold(hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cache mk_line(input logic v, input logic [11:0] t, input mesiStates m);
        mk_line = '{valid: v, tag: t, mesi: m};
    endfunction

    function automatic logic [31:0] at676(input logic [11:0] t);
        at676 = {t, 20'h19d94};
    endfunction

    task automatic apply(input logic [31:0] o, input logic [31:0] a);
        op   = o;
        addr = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        tests_run++; if (busOp !== NOBUSOP) begin fails++; $display("FAIL reset_busop got %s exp NOBUSOP", busOp.name()); end
        tests_run++; if (snoopResult !== NORESULT) begin fails++; $display("FAIL reset_snoop got %s exp NORESULT", snoopResult.name()); end
        tests_run++; if (message !== NOMESSAGE) begin fails++; $display("FAIL reset_msg got %s exp NOMESSAGE", message.name()); end
        tests_run++; if ({cacheRds, cacheWrs, cacheHits, cacheMisses, hold} !== 160'd0) begin fails++; $display("FAIL reset_counters got %0d %0d %0d %0d hold %0d exp all 0", cacheRds, cacheWrs, cacheHits, cacheMisses, hold); end
        tests_run++; if (llc_arr[IDX][0] !== LINE_INVALID) begin fails++; $display("FAIL reset_line got %h exp %h", llc_arr[IDX][0], LINE_INVALID); end
    endtask

    task automatic test_read_miss;
        apply(32'd0, A0);
        tests_run++; if (busOp !== READ) begin fails++; $display("FAIL rdmiss_busop got %s exp READ", busOp.name()); end
        tests_run++; if (snoopResult !== HIT) begin fails++; $display("FAIL rdmiss_snoop got %s exp HIT", snoopResult.name()); end
        tests_run++; if (message !== SENDLINE) begin fails++; $display("FAIL rdmiss_msg got %s exp SENDLINE", message.name()); end
        tests_run++; if (llc_arr[IDX][0] !== mk_line(1'b1, 12'h100, S)) begin fails++; $display("FAIL rdmiss_line got %h exp %h", llc_arr[IDX][0], mk_line(1'b1, 12'h100, S)); end
        tests_run++; if (cacheRds !== 32'd1 || cacheMisses !== 32'd1 || hold !== 32'd0) begin fails++; $display("FAIL rdmiss_counts got rds %0d miss %0d hold %0d exp 1 1 0", cacheRds, cacheMisses, hold); end
    endtask

    task automatic test_read_hit;
        apply(32'd0, A0);
        tests_run++; if (busOp !== NOBUSOP || message !== SENDLINE) begin fails++; $display("FAIL rdhit_out got %s %s exp NOBUSOP SENDLINE", busOp.name(), message.name()); end
        tests_run++; if (cacheHits !== 32'd1 || llc_arr[IDX][0].mesi !== S) begin fails++; $display("FAIL rdhit_state got hits %0d mesi %s exp 1 S", cacheHits, llc_arr[IDX][0].mesi.name()); end
    endtask

    task automatic test_write_hit_then_snoop;
        apply(32'd1, A0);
        tests_run++; if (busOp !== INVALIDATE) begin fails++; $display("FAIL wrhit_busop got %s exp INVALIDATE", busOp.name()); end
        tests_run++; if (llc_arr[IDX][0].mesi !== M || cacheWrs !== 32'd1 || cacheHits !== 32'd2) begin fails++; $display("FAIL wrhit_state got mesi %s wrs %0d hits %0d exp M 1 2", llc_arr[IDX][0].mesi.name(), cacheWrs, cacheHits); end
        apply(32'd3, A0);
        tests_run++; if (snoopResult !== HITM || message !== GETLINE) begin fails++; $display("FAIL snprd_out got %s %s exp HITM GETLINE", snoopResult.name(), message.name()); end
        tests_run++; if (llc_arr[IDX][0].mesi !== S || busOp !== NOBUSOP || cacheHits !== 32'd2) begin fails++; $display("FAIL snprd_state got mesi %s bus %s hits %0d exp S NOBUSOP 2", llc_arr[IDX][0].mesi.name(), busOp.name(), cacheHits); end
        apply(32'd7, A0);
        tests_run++; if (busOp !== NOBUSOP || snoopResult !== NORESULT || message !== NOMESSAGE) begin fails++; $display("FAIL idle_out got %s %s %s exp idle", busOp.name(), snoopResult.name(), message.name()); end
    endtask

    task automatic test_eviction;
        int bad;
        bad = 0;
        for (int t = 0; t < 16; t++) begin
            apply(32'd1, at676(12'h100 + 12'(t)));
            if (hold !== 32'd0) bad++;
        end
        for (int w = 0; w < 16; w++) begin
            if (llc_arr[IDX][w] !== mk_line(1'b1, 12'h100 + 12'(w), M)) bad++;
        end
        tests_run++; if (bad != 0) begin fails++; $display("FAIL fill16_all_m got %0d bad ways/holds exp 0", bad); end
        apply(32'd1, at676(12'h110));
        tests_run++; if (hold !== 32'd1 || busOp !== WRITE || message !== EVICTLINE) begin fails++; $display("FAIL evict_c1 got hold %0d %s %s exp 1 WRITE EVICTLINE", hold, busOp.name(), message.name()); end
        @(posedge clk); @(negedge clk);
        tests_run++; if (hold !== 32'd0 || busOp !== RWIM || message !== SENDLINE) begin fails++; $display("FAIL evict_c2 got hold %0d %s %s exp 0 RWIM SENDLINE", hold, busOp.name(), message.name()); end
        tests_run++; if (llc_arr[IDX][0] !== mk_line(1'b1, 12'h110, M)) begin fails++; $display("FAIL evict_way0 got %h exp %h", llc_arr[IDX][0], mk_line(1'b1, 12'h110, M)); end
    endtask

    task automatic test_back_to_back;
        apply(32'd1, at676(12'h111));
        tests_run++; if (hold !== 32'd1 || busOp !== WRITE) begin fails++; $display("FAIL b2b_c1 got hold %0d %s exp 1 WRITE", hold, busOp.name()); end
        @(posedge clk); @(negedge clk);
        tests_run++; if (llc_arr[IDX][8] !== mk_line(1'b1, 12'h111, M) || busOp !== RWIM) begin fails++; $display("FAIL b2b_way8 got %h %s exp %h RWIM", llc_arr[IDX][8], busOp.name(), mk_line(1'b1, 12'h111, M)); end
        tests_run++; if (cacheWrs !== 32'd19 || cacheHits !== 32'd3 || cacheMisses !== 32'd18) begin fails++; $display("FAIL b2b_counts got wrs %0d hits %0d miss %0d exp 19 3 18", cacheWrs, cacheHits, cacheMisses); end
    endtask

    task automatic test_hitm_and_invalidate;
        apply(32'd0, 32'h20000001);
        tests_run++; if (busOp !== READ || snoopResult !== HITM) begin fails++; $display("FAIL rdhitm_out got %s %s exp READ HITM", busOp.name(), snoopResult.name()); end
        tests_run++; if (llc_arr[14'd0][0] !== mk_line(1'b1, 12'h200, S) || cacheRds !== 32'd3) begin fails++; $display("FAIL rdhitm_line got %h rds %0d exp %h 3", llc_arr[14'd0][0], cacheRds, mk_line(1'b1, 12'h200, S)); end
        apply(32'd6, 32'h20000001);
        tests_run++; if (message !== INVALIDATELINE || snoopResult !== HIT || busOp !== NOBUSOP) begin fails++; $display("FAIL snpinv_out got %s %s %s exp INVALIDATELINE HIT NOBUSOP", message.name(), snoopResult.name(), busOp.name()); end
        tests_run++; if (llc_arr[14'd0][0].valid !== 1'b0 || llc_arr[14'd0][0].mesi !== I) begin fails++; $display("FAIL snpinv_line got %h exp invalid I", llc_arr[14'd0][0]); end
    endtask

    task automatic test_snoop_rwim_write;
        apply(32'd5, at676(12'h101));
        tests_run++; if (snoopResult !== HITM || message !== EVICTLINE || llc_arr[IDX][1].mesi !== I) begin fails++; $display("FAIL snprwim_m got %s %s mesi %s exp HITM EVICTLINE I", snoopResult.name(), message.name(), llc_arr[IDX][1].mesi.name()); end
        apply(32'd5, at676(12'h101));
        tests_run++; if (snoopResult !== NOHIT || message !== NOMESSAGE) begin fails++; $display("FAIL snprwim_miss got %s %s exp NOHIT NOMESSAGE", snoopResult.name(), message.name()); end
        apply(32'd4, at676(12'h102));
        tests_run++; if (snoopResult !== NORESULT || llc_arr[IDX][2].mesi !== M) begin fails++; $display("FAIL snpwr got %s mesi %s exp NORESULT M", snoopResult.name(), llc_arr[IDX][2].mesi.name()); end
        apply(32'd6, at676(12'h102));
        tests_run++; if (snoopResult !== NOHIT || llc_arr[IDX][2].mesi !== M) begin fails++; $display("FAIL snpinv_m got %s mesi %s exp NOHIT M", snoopResult.name(), llc_arr[IDX][2].mesi.name()); end
        tests_run++; if (cacheRds !== 32'd3 || cacheWrs !== 32'd19 || cacheHits !== 32'd3 || cacheMisses !== 32'd19) begin fails++; $display("FAIL pre_flush_counts got %0d %0d %0d %0d exp 3 19 3 19", cacheRds, cacheWrs, cacheHits, cacheMisses); end
    endtask

    task automatic test_flush_and_inspect;
        int bad;
        apply(32'd8, 32'd0);
        tests_run++; if ({cacheRds, cacheWrs, cacheHits, cacheMisses} !== 128'd0) begin fails++; $display("FAIL flush_counts got %0d %0d %0d %0d exp 0", cacheRds, cacheWrs, cacheHits, cacheMisses); end
        bad = 0;
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < ASSOCIATIVITY; w++)
                if (llc_arr[s][w].valid !== 1'b0 || llc_arr[s][w].mesi !== I) bad++;
        tests_run++; if (bad != 0) begin fails++; $display("FAIL flush_array got %0d valid lines exp 0", bad); end
        apply(32'd0, A0);
        apply(32'd9, 32'd0);
        tests_run++; if (busOp !== NOBUSOP || snoopResult !== NORESULT || message !== NOMESSAGE) begin fails++; $display("FAIL op9_out got %s %s %s exp idle", busOp.name(), snoopResult.name(), message.name()); end
        tests_run++; if (llc_arr[IDX][0] !== mk_line(1'b1, 12'h100, S) || cacheRds !== 32'd1) begin fails++; $display("FAIL op9_state got %h rds %0d exp %h 1", llc_arr[IDX][0], cacheRds, mk_line(1'b1, 12'h100, S)); end
    endtask

    task automatic test_reset_mid_hold;
        for (int t = 1; t < 16; t++) apply(32'd0, at676(12'h100 + 12'(t)));
        apply(32'd0, at676(12'h120));
        tests_run++; if (hold !== 32'd1 || busOp !== NOBUSOP || message !== EVICTLINE) begin fails++; $display("FAIL holdS_c1 got hold %0d %s %s exp 1 NOBUSOP EVICTLINE", hold, busOp.name(), message.name()); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (hold !== 32'd0 || message !== NOMESSAGE || cacheRds !== 32'd0 || llc_arr[IDX][0] !== LINE_INVALID) begin fails++; $display("FAIL rst_abort got hold %0d %s rds %0d line %h exp 0 NOMESSAGE 0 invalid", hold, message.name(), cacheRds, llc_arr[IDX][0]); end
        @(negedge clk);
        rst = 1'b0;
        apply(32'd0, A0);
        tests_run++; if (busOp !== READ || hold !== 32'd0 || llc_arr[IDX][0] !== mk_line(1'b1, 12'h100, S)) begin fails++; $display("FAIL post_rst_read got %s hold %0d line %h exp READ 0 %h", busOp.name(), hold, llc_arr[IDX][0], mk_line(1'b1, 12'h100, S)); end
    endtask

    initial begin
        rst  = 1'b1;
        op   = 32'd7;
        addr = 32'd0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_read_miss;
        test_read_hit;
        test_write_hit_then_snoop;
        test_eviction;
        test_back_to_back;
        test_hitm_and_invalidate;
        test_snoop_rwim_write;
        test_flush_and_inspect;
        test_reset_mid_hold;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
